// File: rtl/sift_dir_bin_iter.sv
// sift_dir_bin_iter: iterative SIFT gradient-orientation binning.
// Quadrant reduction, then cross-product binary search over sub-bins.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   dx, dy              signed gradient (DW bits)
//   ref_bin             dominant bin, sampled at accept
//   in_valid/in_ready   request handshake
//   out_valid/out_ready result handshake
//   bin_out             rotation-normalised bin
//   zero_out            input was the (0,0) vector
// Option: SIFT_DIR_BIN_SIGNED_OUT_EN reads bin_out as signed
//   (-NBINS/2..NBINS/2-1); the bit pattern is the same.
module sift_dir_bin_iter #(
  parameter  int DW    = 9,
  parameter  int NBINS = 16,
  localparam int BW    = $clog2(NBINS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] dx,
  input  logic signed [DW-1:0] dy,
  input  logic [BW-1:0]        ref_bin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0]        bin_out,
  output logic                 zero_out
);

  localparam int Q  = NBINS / 4;
  localparam int JW = BW - 2;
  localparam logic [JW-1:0] BIT_MSB = JW'(1) << (JW - 1);

`ifdef SIFT_DIR_BIN_SIGNED_OUT_EN
  localparam bit SIGNED_OUT = 1'b1;
`else
  localparam bit SIGNED_OUT = 1'b0;
`endif

  if (NBINS < 8 || NBINS > 64 || (NBINS & (NBINS - 1)) != 0)
  begin : g_bad_nbins
    $error("NBINS must be a power of 2 in 8..64");
  end
  if (SIGNED_OUT && NBINS < 8) begin : g_bad_signed
    $error("signed output needs NBINS >= 8");
  end

  // Sector boundary (cos, sin) in Q2.14, first quadrant only.
  function automatic logic [15:0] f_trig(input int k,
                                         input bit sine);
    real a;
    real v;
    a = 6.283185307179586 * real'(k) / real'(NBINS);
    v = sine ? $sin(a) : $cos(a);
    return 16'($rtoi(v * 16384.0 + 0.5));
  endfunction

  logic [15:0] c_tab [Q];
  logic [15:0] s_tab [Q];

  for (genvar k = 0; k < Q; k++) begin : g_tab
    assign c_tab[k] = f_trig(k, 1'b0);
    assign s_tab[k] = f_trig(k, 1'b1);
  end

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t        state_q;
  logic [DW-1:0] x_q, y_q;
  logic [1:0]    quad_q;
  logic [BW-1:0] ref_q;
  logic          zero_q;
  logic [JW-1:0] j_q, bit_q;
  logic [BW-1:0] bin_q;
  logic          zout_q;

  logic accept;

  assign in_ready  = (state_q == IDLE)
                   | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign bin_out   = bin_q;
  assign zero_out  = zout_q;

  // Rotate into the first quadrant; -2^(DW-1) negates to
  // 2^(DW-1), which is exact as a DW-bit unsigned value.
  logic [DW-1:0] nx, ny;
  logic [DW-1:0] rx_d, ry_d;
  logic [1:0]    quad_d;
  logic          zero_d;
  logic          x_neg, y_neg, x_nz, y_nz;

  always_comb begin
    nx     = -dx;
    ny     = -dy;
    x_neg  = dx[DW-1];
    y_neg  = dy[DW-1];
    x_nz   = (dx != '0);
    y_nz   = (dy != '0);
    zero_d = !x_nz & !y_nz;
    rx_d   = '0;
    ry_d   = '0;
    quad_d = 2'd0;
    unique case (1'b1)
      (!x_neg & x_nz & !y_neg): begin
        rx_d   = dx;
        ry_d   = dy;
        quad_d = 2'd0;
      end
      (!(!x_neg & x_nz) & !y_neg & y_nz): begin
        rx_d   = dy;
        ry_d   = nx;
        quad_d = 2'd1;
      end
      (x_neg & !(!y_neg & y_nz)): begin
        rx_d   = nx;
        ry_d   = ny;
        quad_d = 2'd2;
      end
      (!x_neg & y_neg): begin
        rx_d   = ny;
        ry_d   = dx;
        quad_d = 2'd3;
      end
      default: begin
        rx_d   = '0;
        ry_d   = '0;
        quad_d = 2'd0;
      end
    endcase
  end

  // One search step: keep the trial bit when the vector lies
  // on or above the trial boundary (ties go to the higher bin).
  logic [JW-1:0]  trial;
  logic [DW+15:0] py, px;
  logic           keep;
  logic [JW-1:0]  j_d;

  always_comb begin
    trial = j_q | bit_q;
    py    = {16'b0, y_q} * {{DW{1'b0}}, c_tab[trial]};
    px    = {16'b0, x_q} * {{DW{1'b0}}, s_tab[trial]};
    keep  = (py >= px);
    j_d   = keep ? trial : j_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      quad_q  <= '0;
      ref_q   <= '0;
      zero_q  <= 1'b0;
      j_q     <= '0;
      bit_q   <= '0;
      bin_q   <= '0;
      zout_q  <= 1'b0;
    end else if (accept) begin
      x_q     <= rx_d;
      y_q     <= ry_d;
      quad_q  <= quad_d;
      ref_q   <= ref_bin;
      zero_q  <= zero_d;
      j_q     <= '0;
      bit_q   <= BIT_MSB;
      state_q <= SEARCH;
    end else begin
      unique case (state_q)
        SEARCH: begin
          j_q   <= j_d;
          bit_q <= bit_q >> 1;
          if (bit_q[0]) begin
            state_q <= DONE;
            zout_q  <= zero_q;
            bin_q   <= zero_q ? '0
                     : {quad_q, j_d} - ref_q;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sift_dir_bin_iter.sv
// tb_sift_dir_bin_iter: random + directed check of
// sift_dir_bin_iter against an angle-scan reference model.
module tb_sift_dir_bin_iter;

  localparam int DW    = 9;
  localparam int NBINS = 16;
  localparam int Q     = NBINS / 4;
  localparam int BW    = 4;
  localparam int L     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] dx = '0;
  logic signed [DW-1:0] dy = '0;
  logic [BW-1:0]        ref_bin = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [BW-1:0]        bin_out;
  logic                 zero_out;

  int n_vec = 0;
  int n_err = 0;
  int ctab [Q];
  int stab [Q];

  always #5 clk = ~clk;

  sift_dir_bin_iter #(
    .DW   (DW),
    .NBINS(NBINS)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dx       (dx),
    .dy       (dy),
    .ref_bin  (ref_bin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .zero_out (zero_out)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // Reference: exact quadrant rotation, then the largest
  // boundary the vector reaches, found by a plain scan.
  function automatic void model(input int x, input int y,
                                input int r, output int bin,
                                output int z);
    int rx, ry, base, j, rr;
    z = (x == 0 && y == 0) ? 1 : 0;
    if (x > 0 && y >= 0) begin
      rx = x;  ry = y;  base = 0;
    end else if (x <= 0 && y > 0) begin
      rx = y;  ry = -x; base = Q;
    end else if (x < 0 && y <= 0) begin
      rx = -x; ry = -y; base = 2 * Q;
    end else if (x >= 0 && y < 0) begin
      rx = -y; ry = x;  base = 3 * Q;
    end else begin
      rx = 0;  ry = 0;  base = 0;
    end
    j = 0;
    for (int k = 0; k < Q; k++)
      if (longint'(ry) * ctab[k] >= longint'(rx) * stab[k])
        j = k;
    rr = (((base + j - r) % NBINS) + NBINS) % NBINS;
    if (z == 1) rr = 0;
`ifdef SIFT_DIR_BIN_SIGNED_OUT_EN
    if (rr >= NBINS / 2) rr = rr - NBINS;
`endif
    bin = rr;
  endfunction

  function automatic int bin_view();
`ifdef SIFT_DIR_BIN_SIGNED_OUT_EN
    return int'($signed(bin_out));
`else
    return int'(bin_out);
`endif
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return -256;
      2:       return 255;
      3:       return int'($urandom_range(0, 4)) - 2;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  task automatic issue(input int x, input int y, input int r);
    dx       = x[DW-1:0];
    dy       = y[DW-1:0];
    ref_bin  = r[BW-1:0];
    in_valid = 1'b1;
  endtask

  // Called #1 after the accept edge; scrambles the inputs to
  // show they were captured, then checks latency and result.
  task automatic collect(input string tag, input int x,
                         input int y, input int r);
    int cnt, eb, ez;
    model(x, y, r, eb, ez);
    in_valid = 1'b0;
    dx       = DW'($urandom);
    dy       = DW'($urandom);
    ref_bin  = BW'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".lat"}, cnt, L);
    chk({tag, ".bin"}, bin_view(), eb);
    chk({tag, ".zero"}, int'(zero_out), ez);
  endtask

  task automatic run(input string tag, input int x,
                     input int y, input int r);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".rdy"}, int'(in_ready), 1);
    issue(x, y, r);
    @(posedge clk); #1;
    collect(tag, x, y, r);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, ez, cnt;
    for (int k = 0; k < Q; k++) begin
      ctab[k] = $rtoi($cos(6.283185307179586 * k / NBINS)
                      * 16384.0 + 0.5);
      stab[k] = $rtoi($sin(6.283185307179586 * k / NBINS)
                      * 16384.0 + 0.5);
    end

    #12;
    chk("rst.rdy",  int'(in_ready), 1);
    chk("rst.vld",  int'(out_valid), 0);
    chk("rst.bin",  int'(bin_out), 0);
    chk("rst.zero", int'(zero_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("east",  100,    0, 0);
    run("north",   0,  100, 0);
    run("diag",   70,   71, 0);
    run("west", -100,   -1, 0);
    run("tie",  -256, -256, 0);
    run("wrap",  100,    0, 3);
    run("zero",    0,    0, 5);

    // Backpressure, then a same-edge release and new accept.
    out_ready = 1'b0;
    issue(30, -70, 1);
    @(posedge clk); #1;
    collect("bp", 30, -70, 1);
    model(30, -70, 1, eb, ez);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.vld",  int'(out_valid), 1);
      chk("bp.bin",  bin_view(), eb);
      chk("bp.zero", int'(zero_out), ez);
      chk("bp.rdy",  int'(in_ready), 0);
    end
    issue(-100, -1, 0);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_up", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp.taken", int'(out_valid), 0);
    collect("b2b", -100, -1, 0);
    @(posedge clk); #1;

    // Reset one cycle after accept aborts the search.
    issue(100, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort.vld",  int'(out_valid), 0);
    chk("abort.rdy",  int'(in_ready), 1);
    chk("abort.bin",  int'(bin_out), 0);
    chk("abort.zero", int'(zero_out), 0);
    issue(0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("abort.idle", cnt, 0);
    run("after", 0, 100, 0);

    for (int i = 0; i < 150; i++)
      run("rnd", pick(), pick(),
          int'($urandom_range(0, NBINS - 1)));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
